// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and baud-count helpers.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HI
  } rx_state_e;

  // Last count value of one bit period; the counter wraps after this value.
  function automatic int baud_cnt_max(input int freq, input int rate);
    return freq / rate - 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, with a selectable reset value.
module sync_2ff #(
  parameter int              WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // the pre-edge values and the chain really is two stages deep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle valid pulse per good byte, framing-error pulse.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int FREQ = 50_000_000,
  parameter int RATE = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int CNT_MAX   = baud_cnt_max(FREQ, RATE);
  localparam int HALF      = CNT_MAX / 2;
  localparam int CNT_WIDTH = $clog2(CNT_MAX + 1);

  localparam logic [CNT_WIDTH-1:0] CNT_TOP  = CNT_WIDTH'(CNT_MAX);
  localparam logic [CNT_WIDTH-1:0] CNT_HALF = CNT_WIDTH'(HALF);

  logic                 rx_s;
  rx_state_e            state, state_d;
  logic [CNT_WIDTH-1:0] cnt, cnt_d;
  logic [2:0]           bit_idx, bit_idx_d;
  logic [7:0]           shift_reg, shift_d;
  logic [7:0]           data_d;
  logic                 valid_d, ferr_d;
  logic                 en;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start after reset.
  sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (i_rx),
    .q   (rx_s)
  );

  assign en     = (cnt == CNT_TOP);
  assign o_busy = (state != IDLE);

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    bit_idx_d = bit_idx;
    shift_d   = shift_reg;
    data_d    = o_data;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        if (cnt == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      DATA: begin
        if (en) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_reg[7:1]};
          bit_idx_d = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      STOP: begin
        if (en) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_reg;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HI;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      // A stuck-low line reports one error, then waits for the line to recover.
      WAIT_HI: begin
        if (rx_s) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      bit_idx     <= bit_idx_d;
      shift_reg   <= shift_d;
      o_data      <= data_d;
      o_valid     <= valid_d;
      o_frame_err <= ferr_d;
    end
  end

endmodule
